// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage constants: ROM enable levels, valid flags, zero word and
// the default reset/exception vectors.
package pc_fetch_pkg;
    localparam logic        ROM_ENABLE   = 1'b1;
    localparam logic        ROM_DISABLE  = 1'b0;
    localparam logic        VALID        = 1'b1;
    localparam logic        INVALID      = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_0050;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on stall, otherwise captures the fetch,
// replacing the instruction with a bubble when squash is set.
module if_id_reg
    import pc_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        squash,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;

    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        if (!stall) begin
            id_pc_d = pc;
            if (squash) begin
                id_inst_d  = ZERO_WORD;
                id_valid_d = INVALID;
            end else begin
                id_inst_d  = inst;
                id_valid_d = VALID;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc_q    <= ZERO_WORD;
            id_inst_q  <= ZERO_WORD;
            id_valid_q <= INVALID;
        end else begin
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;
endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: registered PC with flush > stall > jump > +4
// priority, feeding the ROM directly and an IF/ID register.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] exc_pc,
    input  logic        jtype,
    input  logic [31:0] jaddr,
    output logic        ce,
    output logic [31:0] pc,
    input  logic [31:0] inst_in,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);
    localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

    logic        ce_q, ce_d;
    logic [31:0] pc_q, pc_d;
    logic        hold, squash;

    always_comb begin
        ce_d   = ROM_ENABLE;
        pc_d   = pc_q;
        hold   = 1'b1;
        squash = 1'b0;
        // The first enabled cycle only turns the ROM on; PC and IF/ID stay put.
        if (ce_q == ROM_DISABLE) begin
            pc_d = PC_RST;
        end else if (flush) begin
            pc_d   = (exc_pc != ZERO_WORD) ? word_align(exc_pc) : word_align(EXC_VEC);
            hold   = 1'b0;
            squash = 1'b1;
        end else if (stall) begin
            hold = 1'b1;
        end else if (jtype) begin
            pc_d   = word_align(jaddr);
            hold   = 1'b0;
            squash = 1'b1;
        end else begin
            pc_d = pc_q + PC_STEP;
            hold = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_q <= ROM_DISABLE;
            pc_q <= PC_RST;
        end else begin
            ce_q <= ce_d;
            pc_q <= pc_d;
        end
    end

    assign ce = ce_q;
    assign pc = pc_q;

    if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .stall    (hold),
        .squash   (squash),
        .pc       (pc_q),
        .inst     (inst_in),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_valid (id_valid)
    );
endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios with literal expectations plus
// randomized traffic checked each cycle against a behavioural model.
module tb_pc_fetch;
    localparam logic [31:0] EXC_VEC = 32'h0000_0050;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, jtype = 1'b0;
    logic [31:0] exc_pc = '0, jaddr = '0;
    logic [31:0] inst_in;
    logic        ce, id_valid;
    logic [31:0] pc, id_pc, id_inst;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign inst_in = rom(pc);

    pc_fetch dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .exc_pc   (exc_pc),
        .jtype    (jtype),
        .jaddr    (jaddr),
        .ce       (ce),
        .pc       (pc),
        .inst_in  (inst_in),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_valid (id_valid)
    );

    // Behavioural model of the fetch stage.
    logic        m_ce, m_valid;
    logic [31:0] m_pc, m_id_pc, m_id_inst;

    function automatic logic [31:0] model_next(input logic [31:0] cur);
        logic [31:0] t;
        if (flush)      t = (exc_pc != 0) ? exc_pc : EXC_VEC;
        else if (jtype) t = jaddr;
        else            t = cur + 32'd4;
        return t & 32'hFFFF_FFFC;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ce      <= 1'b0;
            m_pc      <= 32'h0;
            m_id_pc   <= 32'h0;
            m_id_inst <= 32'h0;
            m_valid   <= 1'b0;
        end else if (!m_ce) begin
            m_ce <= 1'b1;
        end else if (flush || !stall) begin
            m_pc      <= model_next(m_pc);
            m_id_pc   <= m_pc;
            m_id_inst <= (flush || jtype) ? 32'h0 : rom(m_pc);
            m_valid   <= !(flush || jtype);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_ce", {31'b0, ce}, {31'b0, m_ce});
            chk("model_pc", pc, m_pc);
            chk("model_id_pc", id_pc, m_id_pc);
            chk("model_id_inst", id_inst, m_id_inst);
            chk("model_id_valid", {31'b0, id_valid}, {31'b0, m_valid});
        end
    end

    task automatic cyc(input logic s, input logic f, input logic j,
                       input logic [31:0] ja, input logic [31:0] ep);
        stall = s; flush = f; jtype = j; jaddr = ja; exc_pc = ep;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ce"}, {31'b0, ce}, 32'h0);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_id_pc"}, id_pc, 32'h0);
        chk({tag, "_id_inst"}, id_inst, 32'h0);
        chk({tag, "_id_valid"}, {31'b0, id_valid}, 32'h0);
    endtask

    initial begin
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b1;

        // Startup: ce rises first, then pc 4, 8, C.
        cyc(0, 0, 0, 0, 0);
        chk("start_ce", {31'b0, ce}, 32'h1);
        chk("start_pc0", pc, 32'h0);
        chk("start_valid0", {31'b0, id_valid}, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("start_pc4", pc, 32'h4);
        chk("start_id_pc0", id_pc, 32'h0);
        chk("start_id_inst0", id_inst, rom(32'h0));
        chk("start_valid1", {31'b0, id_valid}, 32'h1);
        cyc(0, 0, 0, 0, 0);
        chk("start_pc8", pc, 32'h8);
        chk("start_id_pc4", id_pc, 32'h4);
        cyc(0, 0, 0, 0, 0);
        chk("start_pcC", pc, 32'hC);
        cyc(0, 0, 0, 0, 0);
        chk("pc10", pc, 32'h10);

        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0);
            chk("stall_pc", pc, 32'h10);
            chk("stall_id_pc", id_pc, 32'hC);
            chk("stall_id_inst", id_inst, rom(32'hC));
        end
        cyc(0, 0, 0, 0, 0);
        chk("stall_release_pc", pc, 32'h14);
        chk("stall_release_id_pc", id_pc, 32'h10);

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("pc20", pc, 32'h20);
        cyc(0, 0, 1, 32'h28, 0);
        chk("jump_pc", pc, 32'h28);
        chk("jump_squash_valid", {31'b0, id_valid}, 32'h0);
        chk("jump_squash_inst", id_inst, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("jump_id_pc", id_pc, 32'h28);
        chk("jump_after_valid", {31'b0, id_valid}, 32'h1);

        cyc(1, 1, 1, 32'h40, 0);
        chk("flush_vec_pc", pc, 32'h50);
        chk("flush_inst", id_inst, 32'h0);
        chk("flush_valid", {31'b0, id_valid}, 32'h0);
        cyc(0, 1, 0, 0, 32'h1A);
        chk("flush_excpc", pc, 32'h18);

        cyc(0, 0, 1, 32'hFFFF_FFF8, 0);
        chk("wrap_load", pc, 32'hFFFF_FFF8);
        cyc(0, 0, 0, 0, 0);
        chk("wrap_fc", pc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0);
        chk("wrap_zero", pc, 32'h0);

        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h80, 0);
        chk("stall_beats_jump", pc, 32'h4);
        cyc(0, 0, 1, 32'h83, 0);
        chk("jump_align", pc, 32'h80);

        // Asynchronous reset in the middle of a stall.
        cyc(0, 0, 1, 32'h30, 0);
        chk("pc30", pc, 32'h30);
        cyc(1, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        stall = 1'b0;
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("restart_pc0", pc, 32'h0);
        chk("restart_ce", {31'b0, ce}, 32'h1);
        cyc(0, 0, 0, 0, 0);
        chk("restart_pc4", pc, 32'h4);
        chk("restart_valid", {31'b0, id_valid}, 32'h1);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 5) == 0,
                (($urandom % 2) == 0) ? ($urandom % 256) : $urandom,
                (($urandom % 3) == 0) ? 32'h0 : $urandom);
            if (($urandom % 60) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
